// File: rtl/display_pkg.sv
// Shared sheet limits, widths and sequencer state encoding for the sprite animation path.
package display_pkg;

    localparam int SHEET_X_LIMIT = 2048;
    localparam int SHEET_Y_LIMIT = 1024;
    localparam int FRAME_IDX_W   = 6;
    localparam int COORD_X_W     = 11;
    localparam int COORD_Y_W     = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } seq_state_e;

    function automatic int sheet_rows(input int num_frames, input int per_row);
        return (num_frames + per_row - 1) / per_row;
    endfunction

endpackage

// File: rtl/sheet_coord_counter.sv
// Frame index with col/row tracking and registered sprite window coordinates.
// SPRITE_ANIM_PINGPONG_EN adds a down-step that decrements col/row with borrow.
module sheet_coord_counter
    import display_pkg::*;
#(
    parameter int FRAME_W        = 64,
    parameter int FRAME_H        = 64,
    parameter int NUM_FRAMES     = 6,
    parameter int FRAMES_PER_ROW = 4,
    parameter int SHEET_Y0       = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   step_up,
`ifdef SPRITE_ANIM_PINGPONG_EN
    input  logic                   step_down,
    output logic                   at_first,
`endif
    output logic                   at_last,
    output logic [FRAME_IDX_W-1:0] frame_idx,
    output logic [COORD_X_W-1:0]   sprite_x_left,
    output logic [COORD_X_W-1:0]   sprite_x_right,
    output logic [COORD_Y_W-1:0]   sprite_y_top,
    output logic [COORD_Y_W-1:0]   sprite_y_bottom
);

    localparam logic [FRAME_IDX_W-1:0] COL_LAST   = 6'(FRAMES_PER_ROW - 1);
    localparam logic [FRAME_IDX_W-1:0] FRAME_LAST = 6'(NUM_FRAMES - 1);

    logic [FRAME_IDX_W-1:0] frame_d, frame_q;
    logic [FRAME_IDX_W-1:0] col_d, col_q;
    logic [FRAME_IDX_W-1:0] row_d, row_q;
    logic [COORD_X_W-1:0]   x_left_d, x_left_q, x_right_d, x_right_q;
    logic [COORD_Y_W-1:0]   y_top_d, y_top_q, y_bot_d, y_bot_q;

    assign at_last = (frame_q == FRAME_LAST);
`ifdef SPRITE_ANIM_PINGPONG_EN
    assign at_first = (frame_q == 6'd0);
`endif

    // Next frame/col/row, with coordinates derived from the next col/row so they land together.
    always_comb begin
        frame_d = frame_q;
        col_d   = col_q;
        row_d   = row_q;
        if (clear) begin
            frame_d = 6'd0;
            col_d   = 6'd0;
            row_d   = 6'd0;
        end else if (step_up) begin
            frame_d = frame_q + 6'd1;
            if (col_q == COL_LAST) begin
                col_d = 6'd0;
                row_d = row_q + 6'd1;
            end else begin
                col_d = col_q + 6'd1;
            end
`ifdef SPRITE_ANIM_PINGPONG_EN
        end else if (step_down) begin
            frame_d = frame_q - 6'd1;
            if (col_q == 6'd0) begin
                col_d = COL_LAST;
                row_d = row_q - 6'd1;
            end else begin
                col_d = col_q - 6'd1;
            end
`endif
        end else begin
            frame_d = frame_q;
        end
        x_left_d  = 11'(int'(col_d) * FRAME_W);
        x_right_d = x_left_d + 11'(FRAME_W);
        y_top_d   = 10'(SHEET_Y0 + int'(row_d) * FRAME_H);
        y_bot_d   = y_top_d + 10'(FRAME_H);
    end

    // Counter and coordinate registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q   <= 6'd0;
            col_q     <= 6'd0;
            row_q     <= 6'd0;
            x_left_q  <= 11'd0;
            x_right_q <= 11'(FRAME_W);
            y_top_q   <= 10'(SHEET_Y0);
            y_bot_q   <= 10'(SHEET_Y0 + FRAME_H);
        end else begin
            frame_q   <= frame_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_left_q  <= x_left_d;
            x_right_q <= x_right_d;
            y_top_q   <= y_top_d;
            y_bot_q   <= y_bot_d;
        end
    end

    assign frame_idx       = frame_q;
    assign sprite_x_left   = x_left_q;
    assign sprite_x_right  = x_right_q;
    assign sprite_y_top    = y_top_q;
    assign sprite_y_bottom = y_bot_q;

endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite-sheet frame sequencer: steps frames on vsync after a trigger, tear-free.
// Optional SPRITE_ANIM_PINGPONG_EN plays forward then backward instead of wrapping.
module sprite_anim_seq
    import display_pkg::*;
#(
    parameter int FRAME_W         = 64,
    parameter int FRAME_H         = 64,
    parameter int NUM_FRAMES      = 6,
    parameter int FRAMES_PER_ROW  = 4,
    parameter int SHEET_Y0        = 0,
    parameter int TICKS_PER_FRAME = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync_pulse,
    input  logic                   trigger,
    input  logic                   enable,
    input  logic                   loop,
    output logic [COORD_X_W-1:0]   sprite_x_left,
    output logic [COORD_X_W-1:0]   sprite_x_right,
    output logic [COORD_Y_W-1:0]   sprite_y_top,
    output logic [COORD_Y_W-1:0]   sprite_y_bottom,
    output logic [FRAME_IDX_W-1:0] frame_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int SHEET_W = FRAMES_PER_ROW * FRAME_W;
    localparam int SHEET_H = SHEET_Y0 + sheet_rows(NUM_FRAMES, FRAMES_PER_ROW) * FRAME_H;
    localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_FRAME - 1);

    if (NUM_FRAMES < 2 || NUM_FRAMES > 64) begin : g_bad_num_frames
        $error("sprite_anim_seq: NUM_FRAMES out of range 2..64");
    end
    if (TICKS_PER_FRAME < 1 || TICKS_PER_FRAME > 255) begin : g_bad_ticks
        $error("sprite_anim_seq: TICKS_PER_FRAME out of range 1..255");
    end
    if (FRAMES_PER_ROW < 1 || SHEET_W >= SHEET_X_LIMIT || SHEET_H >= SHEET_Y_LIMIT) begin : g_bad_sheet
        $error("sprite_anim_seq: sheet extents exceed coordinate range");
    end

    seq_state_e state_d, state_q;
    logic [7:0] tick_d, tick_q;
    logic       pending_d, pending_q;
    logic       busy_d, busy_q;
    logic       done_d, done_q;
    logic       cnt_clear, cnt_up, at_last;
`ifdef SPRITE_ANIM_PINGPONG_EN
    logic       cnt_down, at_first;
    logic       dir_d, dir_q;
`endif

    sheet_coord_counter #(
        .FRAME_W        (FRAME_W),
        .FRAME_H        (FRAME_H),
        .NUM_FRAMES     (NUM_FRAMES),
        .FRAMES_PER_ROW (FRAMES_PER_ROW),
        .SHEET_Y0       (SHEET_Y0)
    ) u_coord (
        .clk             (clk),
        .reset           (reset),
        .clear           (cnt_clear),
        .step_up         (cnt_up),
`ifdef SPRITE_ANIM_PINGPONG_EN
        .step_down       (cnt_down),
        .at_first        (at_first),
`endif
        .at_last         (at_last),
        .frame_idx       (frame_idx),
        .sprite_x_left   (sprite_x_left),
        .sprite_x_right  (sprite_x_right),
        .sprite_y_top    (sprite_y_top),
        .sprite_y_bottom (sprite_y_bottom)
    );

    // Sequencer next-state: everything moves only on an enabled vsync; a same-cycle trigger stays pending.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_clear = 1'b0;
        cnt_up    = 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
        cnt_down  = 1'b0;
        dir_d     = dir_q;
`endif
        if (!enable) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q | trigger;
            if (vsync_pulse) begin
                case (state_q)
                    ST_IDLE: begin
                        if (pending_q) begin
                            state_d   = ST_PLAY;
                            tick_d    = 8'd0;
                            cnt_clear = 1'b1;
                            pending_d = trigger;
                            busy_d    = 1'b1;
`ifdef SPRITE_ANIM_PINGPONG_EN
                            dir_d     = 1'b0;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_PLAY: begin
                        if (tick_q != TICK_LAST) begin
                            tick_d = tick_q + 8'd1;
                        end else begin
                            tick_d = 8'd0;
`ifdef SPRITE_ANIM_PINGPONG_EN
                            if (!dir_q) begin
                                if (!at_last) begin
                                    cnt_up = 1'b1;
                                end else begin
                                    cnt_down = 1'b1;
                                    dir_d    = 1'b1;
                                end
                            end else if (!at_first) begin
                                cnt_down = 1'b1;
                            end else if (loop || pending_q) begin
                                cnt_up    = 1'b1;
                                dir_d     = 1'b0;
                                pending_d = trigger;
                            end else begin
                                state_d   = ST_IDLE;
                                cnt_clear = 1'b1;
                                dir_d     = 1'b0;
                                busy_d    = 1'b0;
                                done_d    = 1'b1;
                            end
`else
                            if (!at_last) begin
                                cnt_up = 1'b1;
                            end else if (loop || pending_q) begin
                                cnt_clear = 1'b1;
                                pending_d = trigger;
                            end else begin
                                state_d   = ST_IDLE;
                                cnt_clear = 1'b1;
                                busy_d    = 1'b0;
                                done_d    = 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        state_d   = ST_IDLE;
                        cnt_clear = 1'b1;
                        busy_d    = 1'b0;
                    end
                endcase
            end else begin
                state_d = state_q;
            end
        end
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= 8'd0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Directed bench for sprite_anim_seq at default parameters (4 frames/row, 64x64, 6 frames, 2 ticks).
module tb_sprite_anim_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_pulse = 1'b0;
    logic        trigger = 1'b0;
    logic        enable = 1'b1;
    logic        loop = 1'b0;
    logic [10:0] sprite_x_left, sprite_x_right;
    logic [9:0]  sprite_y_top, sprite_y_bottom;
    logic [5:0]  frame_idx;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sprite_anim_seq dut (
        .clk             (clk),
        .reset           (reset),
        .vsync_pulse     (vsync_pulse),
        .trigger         (trigger),
        .enable          (enable),
        .loop            (loop),
        .sprite_x_left   (sprite_x_left),
        .sprite_x_right  (sprite_x_right),
        .sprite_y_top    (sprite_y_top),
        .sprite_y_bottom (sprite_y_bottom),
        .frame_idx       (frame_idx),
        .busy            (busy),
        .done            (done)
    );

    // Drives a one-cycle vsync; returns at the negedge after the sampling edge.
    task automatic do_vsync();
        @(negedge clk); vsync_pulse = 1'b1;
        @(negedge clk); vsync_pulse = 1'b0;
    endtask

    task automatic do_trigger();
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1; enable = 1'b1; loop = 1'b0; trigger = 1'b0; vsync_pulse = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (sprite_x_left !== 11'd0 || sprite_x_right !== 11'd64 || sprite_y_top !== 10'd0 || sprite_y_bottom !== 10'd64) begin
            n_fail++; $display("FAIL reset_coords: got %0d %0d %0d %0d expected 0 64 0 64", sprite_x_left, sprite_x_right, sprite_y_top, sprite_y_bottom);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || frame_idx !== 6'd0) begin
            n_fail++; $display("FAIL reset_status: got busy=%b done=%b frame=%0d expected 0 0 0", busy, done, frame_idx);
        end
        for (int i = 0; i < 10; i++) begin
            do_vsync();
            n_tests++;
            if (busy !== 1'b0 || frame_idx !== 6'd0 || sprite_x_left !== 11'd0 || sprite_y_top !== 10'd0) begin
                n_fail++; $display("FAIL idle_vsync%0d: got busy=%b frame=%0d x=%0d y=%0d expected 0 0 0 0", i, busy, frame_idx, sprite_x_left, sprite_y_top);
            end
        end
    endtask

    task automatic test_oneshot();
        int ex, ey;
        apply_reset();
        do_trigger();
        do_vsync();
        n_tests++;
        if (busy !== 1'b1 || frame_idx !== 6'd0) begin
            n_fail++; $display("FAIL oneshot_start: got busy=%b frame=%0d expected 1 0", busy, frame_idx);
        end
        for (int f = 1; f < 6; f++) begin
            do_vsync();
            n_tests++;
            if (frame_idx !== 6'(f - 1)) begin
                n_fail++; $display("FAIL oneshot_hold%0d: got %0d expected %0d", f, frame_idx, f - 1);
            end
            do_vsync();
            ex = (f % 4) * 64;
            ey = (f / 4) * 64;
            n_tests++;
            if (frame_idx !== 6'(f) || sprite_x_left !== 11'(ex) || sprite_x_right !== 11'(ex + 64) ||
                sprite_y_top !== 10'(ey) || sprite_y_bottom !== 10'(ey + 64) || busy !== 1'b1) begin
                n_fail++; $display("FAIL oneshot_frame%0d: got f=%0d x=%0d/%0d y=%0d/%0d busy=%b expected f=%0d x=%0d/%0d y=%0d/%0d busy=1",
                                   f, frame_idx, sprite_x_left, sprite_x_right, sprite_y_top, sprite_y_bottom, busy, f, ex, ex + 64, ey, ey + 64);
            end
        end
        do_vsync();
        n_tests++;
        if (done !== 1'b0 || frame_idx !== 6'd5) begin
            n_fail++; $display("FAIL oneshot_last_hold: got done=%b frame=%0d expected 0 5", done, frame_idx);
        end
        do_vsync();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || frame_idx !== 6'd0 || sprite_x_left !== 11'd0 || sprite_y_top !== 10'd0) begin
            n_fail++; $display("FAIL oneshot_done: got done=%b busy=%b frame=%0d x=%0d y=%0d expected 1 0 0 0 0", done, busy, frame_idx, sprite_x_left, sprite_y_top);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_done_width: got done=%b expected 0", done);
        end
    endtask

    task automatic test_retrigger();
        int done_seen;
        apply_reset();
        do_trigger();
        do_vsync();
        done_seen = 0;
        for (int s = 1; s < 12; s++) begin
            if (s == 4) do_trigger();
            do_vsync();
            if (done === 1'b1) done_seen++;
            do_vsync();
            if (done === 1'b1) done_seen++;
            n_tests++;
            if (frame_idx !== 6'(s % 6) || busy !== 1'b1) begin
                n_fail++; $display("FAIL retrig_step%0d: got frame=%0d busy=%b expected %0d 1", s, frame_idx, busy, s % 6);
            end
        end
        n_tests++;
        if (done_seen != 0) begin
            n_fail++; $display("FAIL retrig_no_done: got %0d done pulses expected 0", done_seen);
        end
        do_vsync();
        do_vsync();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL retrig_done: got done=%b busy=%b expected 1 0", done, busy);
        end
    endtask

    task automatic test_coincident();
        apply_reset();
        @(negedge clk); trigger = 1'b1; vsync_pulse = 1'b1;
        @(negedge clk); trigger = 1'b0; vsync_pulse = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL coincident_nostart: got busy=%b expected 0", busy);
        end
        do_vsync();
        n_tests++;
        if (busy !== 1'b1 || frame_idx !== 6'd0) begin
            n_fail++; $display("FAIL coincident_start: got busy=%b frame=%0d expected 1 0", busy, frame_idx);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        do_trigger();
        do_vsync();
        for (int i = 0; i < 4; i++) do_vsync();
        n_tests++;
        if (frame_idx !== 6'd2) begin
            n_fail++; $display("FAIL enable_pre: got frame=%0d expected 2", frame_idx);
        end
        @(negedge clk); enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) do_trigger();
            do_vsync();
        end
        n_tests++;
        if (frame_idx !== 6'd2 || busy !== 1'b1 || sprite_x_left !== 11'd128) begin
            n_fail++; $display("FAIL enable_frozen: got frame=%0d busy=%b x=%0d expected 2 1 128", frame_idx, busy, sprite_x_left);
        end
        @(negedge clk); enable = 1'b1;
        do_vsync();
        n_tests++;
        if (frame_idx !== 6'd2) begin
            n_fail++; $display("FAIL enable_resume_hold: got frame=%0d expected 2", frame_idx);
        end
        do_vsync();
        n_tests++;
        if (frame_idx !== 6'd3) begin
            n_fail++; $display("FAIL enable_resume_step: got frame=%0d expected 3", frame_idx);
        end
        for (int i = 0; i < 6; i++) do_vsync();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL enable_trigger_dropped: got done=%b busy=%b expected 1 0", done, busy);
        end
    endtask

    task automatic test_loop();
        apply_reset();
        @(negedge clk); loop = 1'b1;
        do_trigger();
        do_vsync();
        for (int i = 0; i < 12; i++) do_vsync();
        n_tests++;
        if (frame_idx !== 6'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL loop_wrap: got frame=%0d busy=%b done=%b expected 0 1 0", frame_idx, busy, done);
        end
        do_vsync(); do_vsync();
        n_tests++;
        if (frame_idx !== 6'd1) begin
            n_fail++; $display("FAIL loop_continue: got frame=%0d expected 1", frame_idx);
        end
    endtask

    task automatic test_reset_mid_play();
        apply_reset();
        do_trigger();
        do_vsync();
        for (int i = 0; i < 8; i++) do_vsync();
        n_tests++;
        if (frame_idx !== 6'd4 || sprite_x_left !== 11'd0 || sprite_y_top !== 10'd64 || sprite_y_bottom !== 10'd128) begin
            n_fail++; $display("FAIL midreset_pre: got frame=%0d x=%0d y=%0d/%0d expected 4 0 64/128", frame_idx, sprite_x_left, sprite_y_top, sprite_y_bottom);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (frame_idx !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || sprite_x_left !== 11'd0 || sprite_x_right !== 11'd64 ||
            sprite_y_top !== 10'd0 || sprite_y_bottom !== 10'd64) begin
            n_fail++; $display("FAIL midreset_values: got f=%0d busy=%b done=%b x=%0d/%0d y=%0d/%0d expected 0 0 0 0/64 0/64",
                               frame_idx, busy, done, sprite_x_left, sprite_x_right, sprite_y_top, sprite_y_bottom);
        end
        reset = 1'b0;
        do_vsync();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pending_cleared: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_retrigger();
        test_coincident();
        test_enable();
        test_loop();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
